// File: rtl/time_base_multi.sv
// Multi-channel programmable tick generator: each channel divides clk by its own
// divisor, periodic or one-shot, with shadowed divisor updates applied at period boundaries.

module time_base_ch #(
  parameter int              CNT_W   = 26,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ch_en,
  input  logic             oneshot,
  input  logic             start,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdiv,
  output logic             pulse,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic [CNT_W-1:0] div_shd, div_shd_nxt;
  logic [CNT_W-1:0] div_load;
  logic             pulse_nxt;

  // A write landing on the same edge as a reload wins over the old shadow
  assign div_load = wr ? wdiv : div_shd;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_shd_nxt = div_load;
    div_act_nxt = (wr && state == IDLE) ? wdiv : div_act;
    pulse_nxt   = 1'b0;
    if (!ch_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == IDLE) begin
      if (enable && (!oneshot || start)) begin
        state_nxt   = RUN;
        cnt_nxt     = '0;
        div_act_nxt = div_load;
      end
    end else if (enable) begin
      if (start) begin
        cnt_nxt     = '0;
        div_act_nxt = div_load;
      end else if (cnt == div_act - CNT_W'(1)) begin
        cnt_nxt     = '0;
        pulse_nxt   = 1'b1;
        div_act_nxt = div_load;
        if (oneshot) state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_act <= DIV_RST;
      div_shd <= DIV_RST;
      pulse   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_act <= div_act_nxt;
      div_shd <= div_shd_nxt;
      pulse   <= pulse_nxt;
    end
  end

  assign busy = (state == RUN);
endmodule

module time_base_multi #(
  parameter int                      NUM_CH   = 3,
  parameter int                      CNT_W    = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {26'd25000000, 26'd2500, 26'd2},
  localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] busy,
  output logic              cfg_err
);
  localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

  logic ch_valid, cfg_ok;
  assign ch_valid = ({1'b0, cfg_ch} < NUM_CH_L);
  assign cfg_ok   = ch_valid && (cfg_div != '0);

  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
    time_base_ch #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .ch_en  (ch_enable[i]),
      .oneshot(oneshot[i]),
      .start  (start[i]),
      .wr     (wr),
      .wdiv   (cfg_div),
      .pulse  (pulse[i]),
      .busy   (busy[i])
    );
  end
endmodule

// File: tb/tb_time_base_multi.sv
// Directed bench for time_base_multi: periodic rates, freeze, one-shot, divisor
// shadowing/bypass, rejected writes and mid-period reset.

module tb_time_base_multi;
  logic       clk = 1'b0;
  logic       reset, enable, cfg_we, cfg_err;
  logic [2:0] ch_enable, oneshot, start, pulse, busy;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  int n_cmp = 0;
  int n_err = 0;
  int t;

  always #5 clk = ~clk;

  time_base_multi #(
    .NUM_CH  (3),
    .CNT_W   (8),
    .DIV_INIT({8'd4, 8'd3, 8'd2})
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .ch_enable(ch_enable),
    .oneshot  (oneshot),
    .start    (start),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .pulse    (pulse),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] p, input logic [2:0] b);
    chk({tag, "/pulse"}, 32'(pulse), 32'(p));
    chk({tag, "/busy"},  32'(busy),  32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_per(input int n);
    return {n % 4 == 0, n % 3 == 0, n % 2 == 0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1; enable = 0; ch_enable = 0; oneshot = 0; start = 0;
    cfg_we = 0; cfg_ch = 0; cfg_div = 0;
    step(); step();
    chk_out("rst", 3'b000, 3'b000);
    chk("rst/err", 32'(cfg_err), 0);

    // Periodic rates 2/3/4, first RUN entry on first edge out of reset
    reset = 0; enable = 1; ch_enable = 3'b111;
    step();
    chk_out("entry", 3'b000, 3'b111);
    t = 0;
    for (int k = 0; k < 13; k++) begin
      step(); t++;
      chk_out("per", exp_per(t), 3'b111);
    end
    // Freeze: no pulses, phase resumes in active cycles only
    enable = 0;
    repeat (5) begin
      step();
      chk_out("frz", 3'b000, 3'b111);
    end
    enable = 1;
    for (int k = 0; k < 7; k++) begin
      step(); t++;
      chk_out("resume", exp_per(t), 3'b111);
    end
    ch_enable = 3'b000;
    step();
    chk_out("chdis", 3'b000, 3'b000);

    // One-shot on channel 0, divisor 5 written while IDLE
    reset = 1; step();
    chk_out("rst2", 3'b000, 3'b000);
    reset = 0; ch_enable = 3'b001; oneshot = 3'b001;
    cfg_we = 1; cfg_ch = 0; cfg_div = 8'd5;
    step();
    chk_out("os/idle", 3'b000, 3'b000);
    chk("os/wr_err", 32'(cfg_err), 0);
    cfg_we = 0; enable = 0; start = 3'b001;
    step();
    start = 0; enable = 1;
    step();
    chk_out("os/nostart", 3'b000, 3'b000);
    start = 3'b001; step(); start = 0;
    chk_out("os/arm", 3'b000, 3'b001);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_out("os/run", (k == 5) ? 3'b001 : 3'b000, (k == 5) ? 3'b000 : 3'b001);
    end
    step();
    chk_out("os/done", 3'b000, 3'b000);
    start = 3'b001; step(); start = 0;
    chk_out("os/arm2", 3'b000, 3'b001);
    repeat (3) begin
      step();
      chk_out("os/pre", 3'b000, 3'b001);
    end
    start = 3'b001; step(); start = 0;
    chk_out("os/restart", 3'b000, 3'b001);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_out("os/run2", (k == 5) ? 3'b001 : 3'b000, (k == 5) ? 3'b000 : 3'b001);
    end

    // Channel 2: shadowed write at cnt=1, bypass write on a wrap, rejected writes
    reset = 1; oneshot = 0; step();
    reset = 0; ch_enable = 3'b100;
    step();
    chk_out("sh/entry", 3'b000, 3'b100);
    for (int e = 1; e <= 19; e++) begin
      cfg_we = 0; cfg_ch = 2; cfg_div = 0;
      if (e == 2)  begin cfg_we = 1; cfg_div = 8'd6; end
      if (e == 10) begin cfg_we = 1; cfg_div = 8'd3; end
      if (e == 17) begin cfg_we = 1; cfg_div = 8'd0; end
      if (e == 18) begin cfg_we = 1; cfg_ch = 3; cfg_div = 8'd7; end
      step();
      chk_out("sh", (e == 4 || e == 10 || e == 13 || e == 16 || e == 19) ? 3'b100 : 3'b000,
              3'b100);
      chk("sh/err", 32'(cfg_err), (e == 17 || e == 18) ? 1 : 0);
    end
    cfg_we = 0; cfg_ch = 0;

    // Reset at cnt=2 of divisor 4 with a write and starts pending
    reset = 1; step();
    reset = 0; ch_enable = 3'b100;
    step(); step(); step();
    reset = 1; cfg_we = 1; cfg_ch = 2; cfg_div = 8'd7; start = 3'b111; ch_enable = 3'b111;
    step();
    chk_out("rstmid", 3'b000, 3'b000);
    chk("rstmid/err", 32'(cfg_err), 0);
    reset = 0; cfg_we = 0; start = 0; ch_enable = 3'b100;
    step();
    chk_out("rstmid/entry", 3'b000, 3'b100);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_out("rstmid/run", (k == 4) ? 3'b100 : 3'b000, 3'b100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
